display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 50000, defining clk cycles per digit slot (legal range 32..2^20).
REQ-002 The module SHALL have ports `clk`, input, 1 bit: single system clock, rising-edge.
REQ-003 The module SHALL have ports `rst_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have ports `value1`, `value2` and `value3`, each input, 6 bits: unsigned display values, 0..63.
REQ-005 The module SHALL have port `en`, input, 1 bit: display enable; 0 blanks all digits.
REQ-006 The module SHALL have port `an`, output, 6 bits: digit selects, active-low; bit 0 is the rightmost digit.
REQ-007 The module SHALL have port `seg`, output, 7 bits: segments g..a, active-low.
REQ-008 The module SHALL have port `frame`, output, 1 bit: one-cycle pulse when new BCD digits are committed.

Function
REQ-009 Slot counter SHALL count 0..REFRESH_DIV-1 and wrap; at each wrap the digit index SHALL advance 0->1->...->5->0.
REQ-010 Digit index mapping SHALL be: 0/1 = value3 units/tens, 2/3 = value2 units/tens, 4/5 = value1 units/tens.
REQ-011 Exactly one `an` bit SHALL be low when en=1; all `an` bits SHALL be high when en=0; the scan SHALL keep running when en=0.
REQ-012 Converter FSM states SHALL be IDLE, SAMPLE, CONV and COMMIT.
REQ-013 IDLE->SAMPLE SHALL occur on the cycle the digit index wraps 5->0.
REQ-014 SAMPLE SHALL snapshot value1..3 in 1 cycle, then go to CONV.
REQ-015 CONV SHALL perform shift-add-3 binary-to-BCD on each value sequentially, 6 iterations per value, 18 cycles total.
REQ-016 CONV SHALL go to COMMIT after 18 cycles.
REQ-017 COMMIT SHALL load all six display BCD registers simultaneously and pulse `frame` for exactly 1 cycle, then go to IDLE.
REQ-018 Latency from the SAMPLE cycle to the `frame` pulse SHALL be 20 cycles.
REQ-019 Inputs changing during CONV SHALL NOT affect the conversion in progress; the change SHALL be captured at the next frame.
REQ-020 Display registers SHALL hold their previous values until COMMIT, so no partial update is ever shown.
REQ-021 Tens digit SHALL be 0..6 and units digit SHALL be 0..9; no other BCD code SHALL be produced.
REQ-022 Decoder SHALL map 0..9 to standard patterns; undefined codes SHALL drive all segments off (7'h7F).
REQ-023 `seg` and `an` SHALL be registered and change together on the slot-wrap edge.

Reset
REQ-024 While rst_n=0 the block SHALL force: an=6'h3F, seg=7'h7F, frame=0, FSM=IDLE, slot counter=0, digit index=0, all BCD registers=0.
REQ-025 On rst_n release, the first SAMPLE SHALL occur at the first 5->0 index wrap, i.e. after 6*REFRESH_DIV cycles.
REQ-026 Reset asserted mid-CONV SHALL abort the conversion and leave no partial COMMIT.

Configuration
REQ-027 With macro DISPLAY_ZERO_BLANK_EN defined, a tens digit equal to 0 SHALL be blanked (its `an` bit high during its slot).
REQ-028 Without DISPLAY_ZERO_BLANK_EN, every tens digit SHALL be displayed, including 0.
REQ-029 DISPLAY_ZERO_BLANK_EN SHALL NOT affect conversion timing or `frame`.

Verification (REFRESH_DIV=32)
REQ-030 Scenario: rst_n=0 for 5 cycles -> an=3F and seg=7F throughout.
REQ-031 Scenario: value1=63, value2=0, value3=9, en=1, after first `frame` -> slots 5..0 show 6,3,0,0,0,9 with seg(6)=7'h02, seg(3)=7'h30, seg(9)=7'h10.
REQ-032 Scenario: change value2 from 0 to 45 five cycles after SAMPLE -> current frame still shows 00, the following frame shows 45, and `frame` is 20 cycles after each SAMPLE.
REQ-033 Scenario: en=0 -> an=3F, and the index keeps advancing (verified by the slot position after en returns to 1).
REQ-034 Scenario: rst_n pulsed low during CONV -> no `frame` pulse, and the display shows 0 at the first post-reset slots.
REQ-035 Scenario: DISPLAY_ZERO_BLANK_EN defined, value3=7 -> an[1] stays high during slot 1 and an[0] goes low with seg=7'h78.

Source files
------------

// File: rtl/display_scan.sv
// display_scan: 6-digit multiplexed 7-segment scanner showing three 0..63
// values as two BCD digits each, with a shift-add-3 converter that commits
// whole frames at once.
// Ports:
//   clk, rst_n (async, active-low)
//   value1/value2/value3 [5:0] : values shown on digits 5:4 / 3:2 / 1:0
//   en                         : display enable, 0 blanks all digits
//   an [5:0]                   : digit selects, active-low, bit 0 rightmost
//   seg [6:0]                  : segments g..a, active-low
//   frame                      : 1-cycle pulse when new digits are committed
// Build option: define DISPLAY_ZERO_BLANK_EN to blank tens digits equal to 0.
module display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] value1,
    input  logic [5:0] value2,
    input  logic [5:0] value3,
    input  logic       en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       frame
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_MAX = CW'(REFRESH_DIV - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SAMPLE = 2'd1;
    localparam logic [1:0] S_CONV   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [CW-1:0]   r_slot;
    logic [2:0]      r_idx;
    logic [1:0]      r_state;
    logic [2:0]      r_iter;
    logic [1:0]      r_sel;
    logic [5:0]      r_snap1;
    logic [5:0]      r_snap2;
    logic [5:0]      r_snap3;
    logic [5:0]      r_shift;
    logic [3:0]      r_tens;
    logic [3:0]      r_units;
    logic [5:0][3:0] r_res;
    logic [5:0][3:0] r_disp;
    logic [5:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_frame;

    logic            w_wrap;
    logic [2:0]      w_idx_nxt;
    logic [3:0]      w_digit;
    logic            w_zblank;
    logic            w_blank;
    logic [5:0]      w_an_nxt;
    logic [6:0]      w_seg_nxt;
    logic [5:0]      w_snap_sel;
    logic [5:0]      w_src;
    logic [3:0]      w_t_src;
    logic [3:0]      w_u_src;
    logic [3:0]      w_t_adj;
    logic [3:0]      w_u_adj;
    logic [3:0]      w_t_n;
    logic [3:0]      w_u_n;
    logic [5:0]      w_sh_n;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ---------------- scan timing ----------------
    assign w_wrap    = (r_slot == SLOT_MAX);
    assign w_idx_nxt = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
            r_idx  <= 3'd0;
        end else if (w_wrap) begin
            r_slot <= '0;
            r_idx  <= w_idx_nxt;
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    // ---------------- digit output ----------------
    // an/seg are prepared for the slot being entered so both switch
    // together on the wrap edge.
    assign w_digit = r_disp[w_idx_nxt];

`ifdef DISPLAY_ZERO_BLANK_EN
    assign w_zblank = w_idx_nxt[0] && (w_digit == 4'd0);
`else
    assign w_zblank = 1'b0;
`endif

    assign w_blank   = !en || w_zblank;
    assign w_an_nxt  = w_blank ? 6'h3F : ~(6'b000001 << w_idx_nxt);
    assign w_seg_nxt = w_blank ? 7'h7F : f_seg(w_digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 6'h3F;
            r_seg <= 7'h7F;
        end else if (w_wrap) begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    // ---------------- BCD converter ----------------
    // sel 0/1/2 converts value3/value2/value1; the first iteration of each
    // value starts from the snapshot with cleared BCD digits.
    always_comb begin
        w_snap_sel = r_snap1;
        case (r_sel)
            2'd0:    w_snap_sel = r_snap3;
            2'd1:    w_snap_sel = r_snap2;
            default: w_snap_sel = r_snap1;
        endcase
    end

    assign w_src   = (r_iter == 3'd0) ? w_snap_sel : r_shift;
    assign w_t_src = (r_iter == 3'd0) ? 4'd0 : r_tens;
    assign w_u_src = (r_iter == 3'd0) ? 4'd0 : r_units;
    assign w_u_adj = (w_u_src >= 4'd5) ? w_u_src + 4'd3 : w_u_src;
    assign w_t_adj = (w_t_src >= 4'd5) ? w_t_src + 4'd3 : w_t_src;
    assign w_t_n   = {w_t_adj[2:0], w_u_adj[3]};
    assign w_u_n   = {w_u_adj[2:0], w_src[5]};
    assign w_sh_n  = {w_src[4:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_iter  <= 3'd0;
            r_sel   <= 2'd0;
            r_snap1 <= 6'd0;
            r_snap2 <= 6'd0;
            r_snap3 <= 6'd0;
            r_shift <= 6'd0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
            r_res   <= '0;
            r_disp  <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_wrap && r_idx == 3'd5) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_snap1 <= value1;
                    r_snap2 <= value2;
                    r_snap3 <= value3;
                    r_iter  <= 3'd0;
                    r_sel   <= 2'd0;
                    r_state <= S_CONV;
                end
                S_CONV: begin
                    r_shift <= w_sh_n;
                    r_tens  <= w_t_n;
                    r_units <= w_u_n;
                    if (r_iter == 3'd5) begin
                        r_res[{r_sel, 1'b1}] <= w_t_n;
                        r_res[{r_sel, 1'b0}] <= w_u_n;
                        r_iter <= 3'd0;
                        r_sel  <= r_sel + 2'd1;
                        if (r_sel == 2'd2) begin
                            r_state <= S_COMMIT;
                        end
                    end else begin
                        r_iter <= r_iter + 3'd1;
                    end
                end
                S_COMMIT: begin
                    r_disp  <= r_res;
                    r_frame <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign frame = r_frame;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: random/directed stimulus for display_scan checked every
// cycle against a frame-level reference model.
module tb_display_scan;

    localparam int RD = 32;
    localparam int P  = 6 * RD;

`ifdef DISPLAY_ZERO_BLANK_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [5:0] value1;
    logic [5:0] value2;
    logic [5:0] value3;
    logic       en;
    logic [5:0] an;
    logic [6:0] seg;
    logic       frame;

    int n_assert = 0;
    int n_fail   = 0;

    int n;
    int disp [6];
    int s1, s2, s3;
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_frame;
    bit         seg_chk;

    display_scan #(.REFRESH_DIV(RD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .value1 (value1),
        .value2 (value2),
        .value3 (value3),
        .en     (en),
        .an     (an),
        .seg    (seg),
        .frame  (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic model_reset();
        n = 0;
        foreach (disp[i]) disp[i] = 0;
        s1 = 0;
        s2 = 0;
        s3 = 0;
        exp_an = 6'h3F;
        exp_seg = 7'h7F;
        exp_frame = 1'b0;
        seg_chk = 1'b1;
    endtask

    task automatic tick();
        int pv1, pv2, pv3, slot, d;
        bit pen, blank;
        logic [5:0] one;
        pv1 = int'(value1);
        pv2 = int'(value2);
        pv3 = int'(value3);
        pen = en;
        one = 6'b000001;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            n++;
            exp_frame = (n > P) && ((n % P) == 20);
            if (n > P && (n % P) == 1) begin
                s1 = pv1;
                s2 = pv2;
                s3 = pv3;
            end
            if ((n % RD) == 0) begin
                slot = (n / RD) % 6;
                d = disp[slot];
                blank = !pen || (ZB && (slot % 2 == 1) && d == 0);
                exp_an = blank ? 6'h3F : ~(one << slot);
                exp_seg = seg_of(d);
                seg_chk = !blank;
            end
            if (exp_frame) begin
                disp[0] = s3 % 10;
                disp[1] = s3 / 10;
                disp[2] = s2 % 10;
                disp[3] = s2 / 10;
                disp[4] = s1 % 10;
                disp[5] = s1 / 10;
            end
        end
        n_assert++;
        assert (frame === exp_frame) else begin
            n_fail++;
            $error("FAIL frame n=%0d got %b exp %b", n, frame, exp_frame);
        end
        n_assert++;
        assert (an === exp_an) else begin
            n_fail++;
            $error("FAIL an n=%0d got %h exp %h", n, an, exp_an);
        end
        if (seg_chk) begin
            n_assert++;
            assert (seg === exp_seg) else begin
                n_fail++;
                $error("FAIL seg n=%0d got %h exp %h", n, seg, exp_seg);
            end
        end
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        value1 = 6'($urandom_range(0, 63));
        value2 = 6'($urandom_range(0, 63));
        value3 = 6'($urandom_range(0, 63));
        model_reset();

        run(5);

        rst_n  = 1'b1;
        value1 = 6'd63;
        value2 = 6'd0;
        value3 = 6'd9;
        en     = 1'b1;
        while (n < 2 * P + 5) tick();

        value2 = 6'd45;
        while (n < 4 * P + 40) tick();

        en = 1'b0;
        run(200);
        en = 1'b1;
        run(P);

        value3 = 6'd7;
        value2 = 6'd10;
        run(2 * P);

        for (int k = 0; k < 6; k++) begin
            value1 = 6'($urandom_range(0, 63));
            value2 = 6'($urandom_range(0, 63));
            value3 = 6'($urandom_range(0, 63));
            en = ($urandom_range(0, 3) != 0);
            run($urandom_range(50, 300));
        end
        en = 1'b1;

        while (!(n > P && (n % P) == 5)) tick();
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(P + 40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
